universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port I, input, WIDTH bits: parallel load data.
REQ-005 The block SHALL have port s, input, 2 bits: mode select.
REQ-006 The block SHALL have port leftshift, input, 1 bit: serial data entering at bit 0 during a left shift.
REQ-007 The block SHALL have port rightshift, input, 1 bit: serial data entering at bit WIDTH-1 during a right shift.
REQ-008 The block SHALL have port OUT, output, WIDTH bits: the current register contents, driven directly from flops.

Function
REQ-009 With s=00 (hold), the register SHALL keep its value at each rising clk edge.
REQ-010 With s=01 (shift right), the register SHALL become {rightshift, OUT[WIDTH-1:1]} at the next rising edge.
REQ-011 With s=10 (shift left), the register SHALL become {OUT[WIDTH-2:0], leftshift} at the next rising edge.
REQ-012 With s=11 (parallel load), the register SHALL become I at the next rising edge.
REQ-013 Every mode SHALL have 1-cycle latency, and OUT SHALL reflect the new value after that edge with no combinational path from any input to OUT.
REQ-014 Inputs I, s, leftshift and rightshift SHALL be sampled only at the rising clk edge; changes between edges SHALL have no effect.
REQ-015 In a shift, the bit shifted out (bit 0 on right, bit WIDTH-1 on left) SHALL be discarded; no carry output is provided.
REQ-016 If s is X/Z, the register SHALL keep its value, matching hold behaviour.
REQ-017 There SHALL be no handshake and no busy state; a new mode SHALL be accepted every cycle.

Reset
REQ-018 When reset is low, OUT SHALL go to all zeros immediately, without waiting for a clock edge.
REQ-019 While reset is low, clock edges SHALL be ignored and OUT SHALL stay zero.
REQ-020 On reset deassertion, the first rising edge with reset high SHALL perform the operation selected by s.
REQ-021 Reset asserted in the middle of a shift sequence SHALL abort the sequence, with no residual state kept.

Structure
REQ-022 The mode encodings SHALL be named constants in a shared package: MODE_HOLD=00, MODE_SHR=01, MODE_SHL=10, MODE_LOAD=11.
REQ-023 Each bit SHALL be built from one sub-module, usr_bit_cell: a 4:1 mux (hold, right-neighbour, left-neighbour, I[k]) feeding a D flip-flop with asynchronous active-low clear.
REQ-024 The top level SHALL instantiate WIDTH usr_bit_cell instances in a generate loop.
REQ-025 In that loop, the edge cells SHALL take rightshift (at MSB) and leftshift (at LSB) as their neighbour inputs.

Verification
REQ-026 Scenario: reset=0 for 100 ns with clock running -> OUT=00000000.
REQ-027 Scenario: reset=1, s=11, I=00001010, one edge -> OUT=00001010.
REQ-028 Scenario: s=01, rightshift=1, one edge -> OUT=10000101.
REQ-029 Scenario: s=10, leftshift=0, one edge -> OUT=00001010; three further edges -> OUT=01010000.
REQ-030 Scenario: s=00, I toggled arbitrarily over five edges -> OUT unchanged.
REQ-031 Scenario: OUT=11111111, reset pulsed low between clock edges -> OUT=00000000 within the same time step; next edge with s=11, I=10101010 -> OUT=10101010.

Source files
------------

// File: rtl/universal_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg_pkg
//   Shared definitions for the universal shift register and its bit cells.
//   - mode_e        : two-bit mode select encoding (hold / shift right /
//                     shift left / parallel load)
//   - USR_DEFAULT_WIDTH : default register width
// ---------------------------------------------------------------------------
package universal_shift_reg_pkg;

  localparam int USR_DEFAULT_WIDTH = 8;

  // Mode select encodings; the top-level port s carries one of these values.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/universal_shift_reg_bit_cell.sv
// ---------------------------------------------------------------------------
// usr_bit_cell
//   One bit of the universal shift register: a 4:1 mux picking the next
//   value, feeding a D flip-flop with asynchronous active-low clear.
//
//   Ports
//     clk       in  : clock, rising edge
//     reset     in  : asynchronous active-low clear
//     sel       in  : mode select (mode_e encoding)
//     fromright in  : value of the more-significant neighbour (shift right)
//     fromleft  in  : value of the less-significant neighbour (shift left)
//     loadbit   in  : parallel load data for this bit
//     q         out : stored bit
// ---------------------------------------------------------------------------
module usr_bit_cell
  import universal_shift_reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       fromright,
  input  logic       fromleft,
  input  logic       loadbit,
  output logic       q
);

  logic d;

  // Next-value mux. An unknown select falls to the default arm and holds,
  // so an X/Z on the mode bits never corrupts the stored value.
  always_comb begin
    d = q;
    case (sel)
      MODE_HOLD: d = q;
      MODE_SHR:  d = fromright;
      MODE_SHL:  d = fromleft;
      MODE_LOAD: d = loadbit;
      default:   d = q;
    endcase
  end

  // Storage flop; the clear is asynchronous so the register empties
  // immediately and stays empty while reset is held low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//   WIDTH-bit universal shift register: hold, shift right, shift left or
//   parallel load, selected every cycle by s. One-cycle latency, OUT comes
//   straight from the bit-cell flops.
//
//   Ports
//     clk        in  : clock, rising edge
//     reset      in  : asynchronous active-low reset, clears OUT to zero
//     I          in  : parallel load data [WIDTH-1:0]
//     s          in  : mode select (00 hold, 01 shr, 10 shl, 11 load)
//     leftshift  in  : serial bit entering bit 0 on a left shift
//     rightshift in  : serial bit entering bit WIDTH-1 on a right shift
//     OUT        out : register contents [WIDTH-1:0]
// ---------------------------------------------------------------------------
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = USR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       s,
  input  logic             leftshift,
  input  logic             rightshift,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] qbits;

  // One cell per bit. A right shift pulls each bit from its upper
  // neighbour and a left shift from its lower neighbour; the edge cells
  // take the serial inputs instead, and the bit leaving the far end is
  // simply dropped.
  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    logic rightsrc;
    logic leftsrc;

    if (k == WIDTH - 1) begin : g_msb
      assign rightsrc = rightshift;
    end else begin : g_mid_r
      assign rightsrc = qbits[k+1];
    end

    if (k == 0) begin : g_lsb
      assign leftsrc = leftshift;
    end else begin : g_mid_l
      assign leftsrc = qbits[k-1];
    end

    usr_bit_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .sel       (s),
      .fromright (rightsrc),
      .fromleft  (leftsrc),
      .loadbit   (I[k]),
      .q         (qbits[k])
    );
  end

  assign OUT = qbits;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed testbench for universal_shift_reg (WIDTH = 8).
module tb_universal_shift_reg;

  logic       clk;
  logic       reset;
  logic [7:0] I;
  logic [1:0] s;
  logic       leftshift;
  logic       rightshift;
  logic [7:0] OUT;

  int checks;
  int errors;

  universal_shift_reg #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .I          (I),
    .s          (s),
    .leftshift  (leftshift),
    .rightshift (rightshift),
    .OUT        (OUT)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the expected one.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive the inputs, then let one rising edge pass and settle just after it.
  task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] data,
                               input logic ls, input logic rs);
    s          = mode;
    I          = data;
    leftshift  = ls;
    rightshift = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held for 100 ns with load selected: edges must be ignored.
    reset = 1'b0; s = 2'b11; I = 8'hFF; leftshift = 1'b1; rightshift = 1'b1;
    #100;
    checkOutput("reset_hold", OUT, 8'b00000000);

    // Release reset; first edge performs the load.
    reset = 1'b1;
    applyStimulus(2'b11, 8'b00001010, 1'b0, 1'b0);
    checkOutput("load_0a", OUT, 8'b00001010);

    applyStimulus(2'b01, 8'h00, 1'b0, 1'b1);
    checkOutput("shr_rs1", OUT, 8'b10000101);

    applyStimulus(2'b10, 8'h00, 1'b0, 1'b0);
    checkOutput("shl_ls0", OUT, 8'b00001010);
    applyStimulus(2'b10, 8'h00, 1'b0, 1'b0);
    applyStimulus(2'b10, 8'h00, 1'b0, 1'b0);
    applyStimulus(2'b10, 8'h00, 1'b0, 1'b0);
    checkOutput("shl_x3", OUT, 8'b01010000);

    // Hold over five edges while I toggles.
    applyStimulus(2'b00, 8'hFF, 1'b1, 1'b1);
    checkOutput("hold_1", OUT, 8'b01010000);
    applyStimulus(2'b00, 8'h00, 1'b0, 1'b0);
    applyStimulus(2'b00, 8'hA5, 1'b1, 1'b0);
    applyStimulus(2'b00, 8'h3C, 1'b0, 1'b1);
    applyStimulus(2'b00, 8'hC3, 1'b1, 1'b1);
    checkOutput("hold_5", OUT, 8'b01010000);

    // Inputs changing between edges have no effect until the edge.
    s = 2'b11; I = 8'h99;
    #2;
    s = 2'b01; rightshift = 1'b1;
    #2;
    checkOutput("between_edges", OUT, 8'b01010000);
    s = 2'b00;

    // Unknown select behaves as hold.
    applyStimulus(2'bxx, 8'hFF, 1'b1, 1'b1);
    checkOutput("sel_x_hold", OUT, 8'b01010000);

    // Shifted-out bits are discarded at both ends.
    applyStimulus(2'b11, 8'b10000001, 1'b0, 1'b0);
    applyStimulus(2'b10, 8'h00, 1'b1, 1'b0);
    checkOutput("shl_drop_msb", OUT, 8'b00000011);
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b0);
    checkOutput("shr_drop_lsb", OUT, 8'b00000001);
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b1);
    checkOutput("shr_in_msb", OUT, 8'b10000000);

    // Asynchronous reset pulse between edges.
    applyStimulus(2'b11, 8'hFF, 1'b0, 1'b0);
    checkOutput("load_ff", OUT, 8'b11111111);
    reset = 1'b0;
    #1;
    checkOutput("async_clear", OUT, 8'b00000000);
    #1;
    reset = 1'b1;
    applyStimulus(2'b11, 8'b10101010, 1'b0, 1'b0);
    checkOutput("load_after_rst", OUT, 8'b10101010);

    // Reset mid-sequence leaves no residue; first edge after release shifts.
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_shift", OUT, 8'b00000000);
    reset = 1'b1;
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b1);
    checkOutput("first_edge_shr", OUT, 8'b10000000);
    applyStimulus(2'b00, 8'hFF, 1'b0, 1'b0);
    checkOutput("post_rst_hold", OUT, 8'b10000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
